// File: rtl/pc_flags_unit.sv
// Architectural PC and status flags with condition evaluation.
// Produces the next fetch address, the link value and a one-cycle redirect pulse.
module pc_flags_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DISP_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PCe,
    input  logic              npc_ctrl,
    input  logic              is_jump,
    input  logic [3:0]        cond,
    input  logic [DISP_W-1:0] disp,
    input  logic [ADDR_W-1:0] jtarget,
    input  logic              flagsEn,
    input  logic [4:0]        alu_flags,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] link,
    output logic [4:0]        flags,
    output logic              taken,
    output logic              redirect
);

    logic              fc, fl, ff, fz, fn;
    logic [ADDR_W-1:0] disp_ext;
    logic [ADDR_W-1:0] pc_next;

    assign {fc, fl, ff, fz, fn} = flags;
    assign disp_ext = {{(ADDR_W-DISP_W){disp[DISP_W-1]}}, disp};
    assign link     = pc + ADDR_W'(1);

    // Condition is judged on the registered flags only.
    always_comb begin
        taken = 1'b0;
        unique case (cond)
            4'h0: taken = fz;
            4'h1: taken = !fz;
            4'h2: taken = fc;
            4'h3: taken = !fc;
            4'h4: taken = fl;
            4'h5: taken = !fl;
            4'h6: taken = fn;
            4'h7: taken = !fn;
            4'h8: taken = ff;
            4'h9: taken = !ff;
            4'hA: taken = !fl && !fz;
            4'hB: taken = fl || fz;
            4'hC: taken = !fn && !fz;
            4'hD: taken = fn || fz;
            4'hE: taken = 1'b1;
            4'hF: taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_next = link;
        if (npc_ctrl && taken) begin
            pc_next = is_jump ? jtarget : pc + disp_ext;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_PC;
            flags    <= '0;
            redirect <= 1'b0;
        end else begin
            if (PCe) begin
                pc <= pc_next;
            end
            if (flagsEn) begin
                flags <= alu_flags;
            end
            redirect <= PCe & npc_ctrl & taken;
        end
    end

endmodule

// File: doc/pc_flags_unit.md
Name: pc_flags_unit

Overview:
- Program-counter and condition-flag stage that sits directly downstream of the CPU control FSM.
- Consumes the FSM's PCe, npc_ctrl and flagsEn strobes together with ALU flag results and decoded branch/jump fields.
- Holds the architectural PC and the processor status flags (C, L, F, Z, N), evaluates the 4-bit condition code, and produces the next fetch address, the link value (PC+1) and a condition-taken indication.

Parameters:
- ADDR_W, 16, width of PC, jump target and link value.
- RESET_PC, 0, PC value loaded on reset.
- DISP_W, 8, width of signed branch displacement.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- PCe  input  1  PC update strobe from the control FSM.
- npc_ctrl  input  1  1 = non-sequential update (branch/jump candidate); 0 = sequential (PC+1).
- is_jump  input  1  with npc_ctrl: 1 = register-target jump, 0 = PC-relative branch.
- cond  input  4  condition code from the instruction.
- disp  input  DISP_W  signed branch displacement.
- jtarget  input  ADDR_W  absolute jump target from the register file.
- flagsEn  input  1  flag-register load strobe from the control FSM.
- alu_flags  input  5  {C,L,F,Z,N} produced by the ALU this cycle.
- pc  output  ADDR_W  current PC; drives the instruction address mux.
- link  output  ADDR_W  pc+1, combinational; written back by JAL-type instructions.
- flags  output  5  registered {C,L,F,Z,N}.
- taken  output  1  combinational: cond evaluated against the registered flags.
- redirect  output  1  registered: 1 for exactly one cycle after a PCe update that loaded a non-sequential address.

Behaviour:
- Reset (asynchronous, reset=0): pc=RESET_PC, flags=0, redirect=0. Takes effect immediately, independent of clk, and overrides any in-flight update. The first rising edge after release behaves normally.
- Condition evaluation (combinational on the registered flags, not alu_flags):
  - 0 EQ: Z.
  - 1 NE: !Z.
  - 2 CS: C.
  - 3 CC: !C.
  - 4 HI: L.
  - 5 LS: !L.
  - 6 GT: N.
  - 7 LE: !N.
  - 8 FS: F.
  - 9 FC: !F.
  - A LO: !L&!Z.
  - B HS: L|Z.
  - C LT: !N&!Z.
  - D GE: N|Z.
  - E UC: 1.
  - F NV: 0.
- PC update, at a rising edge with PCe=1:
  - npc_ctrl=0: pc <= pc+1.
  - npc_ctrl=1, taken=1, is_jump=1: pc <= jtarget.
  - npc_ctrl=1, taken=1, is_jump=0: pc <= pc + sign_extend(disp).
  - npc_ctrl=1, taken=0: pc <= pc+1.
- PCe=0: pc holds, whatever npc_ctrl is.
- Arithmetic is modulo 2^ADDR_W. Wrap is silent: FFFF+1=0000, 0002+(-4)=FFFE.
- redirect <= PCe & npc_ctrl & taken on every edge; otherwise 0.
- Flags: on a rising edge with flagsEn=1, flags <= alu_flags; otherwise they hold.
- Simultaneous flagsEn and PCe with npc_ctrl: taken uses the OLD flags, because the new flags become visible only on the following cycle.
- Latency: pc, flags and redirect change one edge after the strobe. link and taken follow their inputs combinationally with zero latency.
- No other state. Back-to-back PCe pulses each produce one update.

Test Plan:
- Reset release, then 3 edges with PCe=1, npc_ctrl=0 -> pc 0000→0001→0002→0003, redirect stays 0. Assert reset mid-sequence -> pc=0000 immediately, before the next clk.
- flagsEn with alu_flags Z=1, next cycle PCe=1, npc_ctrl=1, is_jump=0, cond=EQ, disp=8'hFC at pc=0010 -> pc=000C, redirect=1 for one cycle. Same with cond=NE -> pc=0011, redirect=0.
- pc=0020, PCe=1, npc_ctrl=1, is_jump=1, cond=UC, jtarget=1234 -> pc=1234 and link was 0021 in the cycle before the edge. Repeat with cond=NV -> pc=0021.
- Same edge flagsEn=1 (Z 0→1) and PCe with cond=EQ -> branch not taken (old Z=0); one cycle later taken=1.
- Wrap: pc=FFFF, PCe, npc_ctrl=0 -> 0000. pc=0002, branch UC, disp=8'h80 -> pc=FF82.
- Exhaustive cond sweep: for all 32 flag combinations × 16 codes, check taken against the table; PCe=0 throughout -> pc unchanged.
